// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style character LCD responder:
// opcode masks, DDRAM geometry, FSM states and the address-counter step rule.
package lcd_pkg;

  // Instruction opcode masks; the highest set bit selects the instruction
  localparam logic [7:0] LCD_CLR   = 8'h01;
  localparam logic [7:0] LCD_HOME  = 8'h02;
  localparam logic [7:0] LCD_ENTRY = 8'h04;
  localparam logic [7:0] LCD_DISP  = 8'h08;
  localparam logic [7:0] LCD_SHIFT = 8'h10;
  localparam logic [7:0] LCD_FUNC  = 8'h20;
  localparam logic [7:0] LCD_CGRAM = 8'h40;
  localparam logic [7:0] LCD_DDRAM = 8'h80;

  // DDRAM line geometry
  localparam logic [6:0] LINE0_BASE = 7'h00;
  localparam logic [6:0] LINE1_BASE = 7'h40;
  localparam logic [6:0] LINE_LEN   = 7'h28;

  localparam logic [7:0] SPACE = 8'h20;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_CLEAR} lcd_state_e;

  // Next address counter value after one step in the given direction.
  // Two-line mode hops between the 40-char lines; one-line mode is mod 80.
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc,
                                         input logic n2);
    logic [6:0] last0, last1;
    last0 = LINE0_BASE + LINE_LEN - 7'd1;
    last1 = LINE1_BASE + LINE_LEN - 7'd1;
    if (n2) begin
      if (inc) ac_step = (ac == last0) ? LINE1_BASE : (ac == last1) ? LINE0_BASE : ac + 7'd1;
      else     ac_step = (ac == LINE0_BASE) ? last1 : (ac == LINE1_BASE) ? last0 : ac - 7'd1;
    end else begin
      if (inc) ac_step = (ac == 7'h4F) ? 7'h00 : ac + 7'd1;
      else     ac_step = (ac == 7'h00) ? 7'h4F : ac - 7'd1;
    end
  endfunction

endpackage

// File: rtl/lcd_bus_sync.sv
// Two-flop synchroniser for the LCD bus (E, RS, RW, DATA) plus E falling-edge detect.
module lcd_bus_sync (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       e_i,
  input  logic       rs_i,
  input  logic       rw_i,
  input  logic [7:0] data_i,
  output logic       e_o,
  output logic       rs_o,
  output logic       rw_o,
  output logic [7:0] data_o,
  output logic       fall_o
);
  logic [10:0] s1_q, s2_q;

  // Resample all 11 bus bits through two stages
  always_ff @(posedge CLK or posedge RESETN) begin
    if (RESETN) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= {e_i, rs_i, rw_i, data_i};
      s2_q <= s1_q;
    end
  end

  assign {e_o, rs_o, rw_o, data_o} = s2_q;
  // s2 still holds the E-high sample while s1 has seen E low
  assign fall_o = s2_q[10] & ~s1_q[10];
endmodule

// File: rtl/lcd_char_responder.sv
// HD44780-compatible bus responder: decodes instructions and data transfers,
// keeps a 128-byte DDRAM image, cursor/mode state and busy timing.
module lcd_char_responder
  import lcd_pkg::*;
#(
  parameter int BUSY_CYC = 4,
  parameter int CLR_CYC  = 128
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       LCD_E,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic [7:0] LCD_DATA_IN,
  output logic [7:0] LCD_DATA_OUT,
  output logic       LCD_DATA_OE,
  output logic       BUSY,
  output logic [6:0] AC,
  output logic       DISP_ON,
  output logic       CURSOR_ON,
  output logic       BLINK_ON,
  output logic       ENTRY_ID,
  output logic       ENTRY_S,
  output logic       DL_8BIT,
  output logic       N_2LINE,
  output logic       WR_STB,
  output logic [6:0] WR_ADDR,
  output logic [7:0] WR_CHAR,
  input  logic [6:0] RD_ADDR,
  output logic [7:0] RD_CHAR,
  output logic       CMD_ERR
);
  localparam int CW = $clog2(CLR_CYC) + 1;

  logic       se, srs, srw, fall;
  logic [7:0] sd;

  lcd_bus_sync u_sync (
    .CLK(CLK), .RESETN(RESETN), .e_i(LCD_E), .rs_i(LCD_RS), .rw_i(LCD_RW),
    .data_i(LCD_DATA_IN), .e_o(se), .rs_o(srs), .rw_o(srw), .data_o(sd), .fall_o(fall)
  );

  lcd_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0]    ac_q, ac_d, wr_addr_q, wr_addr_d;
  logic [7:0]    wr_char_q, wr_char_d;
  logic          disp_q, disp_d, cur_q, cur_d, blink_q, blink_d;
  logic          id_q, id_d, s_q, s_d, dl_q, dl_d, n2_q, n2_d;
  logic          wr_stb_q, wr_stb_d, err_q, err_d;
  logic          mem_we;
  logic [6:0]    mem_addr;
  logic [7:0]    mem_din;
  logic [7:0]    mem_q [128];

  assign BUSY = (state_q != ST_IDLE);

  // State, counters and mode registers; reset restarts the clear sequence
  always_ff @(posedge CLK or posedge RESETN) begin
    if (RESETN) begin
      state_q <= ST_CLEAR;  cnt_q <= '0;     ac_q <= '0;
      disp_q <= 1'b0;  cur_q <= 1'b0;  blink_q <= 1'b0;
      id_q <= 1'b1;  s_q <= 1'b0;  dl_q <= 1'b1;  n2_q <= 1'b0;
      wr_stb_q <= 1'b0;  wr_addr_q <= '0;  wr_char_q <= '0;  err_q <= 1'b0;
    end else begin
      state_q <= state_d;  cnt_q <= cnt_d;  ac_q <= ac_d;
      disp_q <= disp_d;  cur_q <= cur_d;  blink_q <= blink_d;
      id_q <= id_d;  s_q <= s_d;  dl_q <= dl_d;  n2_q <= n2_d;
      wr_stb_q <= wr_stb_d;  wr_addr_q <= wr_addr_d;  wr_char_q <= wr_char_d;  err_q <= err_d;
    end
  end

  // DDRAM image: single write port shared by the clear sweep and data writes
  always_ff @(posedge CLK) begin
    if (mem_we) mem_q[mem_addr] <= mem_din;
  end

  // Busy timing plus decode of the transfer completing on this E fall
  always_comb begin
    state_d = state_q;  cnt_d = cnt_q;  ac_d = ac_q;
    disp_d = disp_q;  cur_d = cur_q;  blink_d = blink_q;
    id_d = id_q;  s_d = s_q;  dl_d = dl_q;  n2_d = n2_q;
    wr_stb_d = 1'b0;  wr_addr_d = wr_addr_q;  wr_char_d = wr_char_q;  err_d = 1'b0;
    mem_we = 1'b0;  mem_addr = ac_q;  mem_din = sd;

    case (state_q)
      ST_EXEC: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else cnt_d = cnt_q - 1'b1;
      end
      ST_CLEAR: begin
        if (cnt_q < CW'(128)) begin
          mem_we = 1'b1;  mem_addr = cnt_q[6:0];  mem_din = SPACE;
        end
        if (cnt_q == CW'(CLR_CYC - 1)) state_d = ST_IDLE;
        else cnt_d = cnt_q + 1'b1;
      end
      default: ;
    endcase

    // Status reads never act; everything else is dropped while busy
    if (fall && (!srw || srs)) begin
      if (BUSY) begin
        err_d = 1'b1;
      end else if (srw) begin
        ac_d = ac_step(ac_q, id_q, n2_q);
      end else begin
        state_d = ST_EXEC;
        cnt_d = CW'(BUSY_CYC - 1);
        if (srs) begin
          mem_we = 1'b1;
          wr_stb_d = 1'b1;  wr_addr_d = ac_q;  wr_char_d = sd;
          ac_d = ac_step(ac_q, id_q, n2_q);
        end else if ((sd & LCD_DDRAM) != 8'h00) begin
          ac_d = sd[6:0];
        end else if ((sd & LCD_CGRAM) != 8'h00) begin
          ac_d = ac_q;
        end else if ((sd & LCD_FUNC) != 8'h00) begin
          dl_d = sd[4];  n2_d = sd[3];
        end else if ((sd & LCD_SHIFT) != 8'h00) begin
          if (!sd[3]) ac_d = ac_step(ac_q, sd[2], n2_q);
        end else if ((sd & LCD_DISP) != 8'h00) begin
          disp_d = sd[2];  cur_d = sd[1];  blink_d = sd[0];
        end else if ((sd & LCD_ENTRY) != 8'h00) begin
          id_d = sd[1];  s_d = sd[0];
        end else if ((sd & LCD_HOME) != 8'h00) begin
          ac_d = '0;
          cnt_d = CW'(CLR_CYC - 1);
        end else if ((sd & LCD_CLR) != 8'h00) begin
          ac_d = '0;  id_d = 1'b1;
          state_d = ST_CLEAR;  cnt_d = '0;
        end
      end
    end
  end

  assign LCD_DATA_OE  = se & srw;
  assign LCD_DATA_OUT = LCD_DATA_OE ? (srs ? mem_q[ac_q] : {BUSY, ac_q}) : 8'h00;
  assign RD_CHAR      = mem_q[RD_ADDR];
  assign AC        = ac_q;
  assign DISP_ON   = disp_q;
  assign CURSOR_ON = cur_q;
  assign BLINK_ON  = blink_q;
  assign ENTRY_ID  = id_q;
  assign ENTRY_S   = s_q;
  assign DL_8BIT   = dl_q;
  assign N_2LINE   = n2_q;
  assign WR_STB    = wr_stb_q;
  assign WR_ADDR   = wr_addr_q;
  assign WR_CHAR   = wr_char_q;
  assign CMD_ERR   = err_q;
endmodule

// File: tb/tb_lcd_char_responder.sv
// Bench for lcd_char_responder: directed table, busy/reset corner sequences,
// then random bus traffic checked against a screen-level reference model.
module tb_lcd_char_responder;
  logic       CLK = 1'b0, RESETN = 1'b1, LCD_E = 1'b0, LCD_RS = 1'b0, LCD_RW = 1'b0;
  logic [7:0] LCD_DATA_IN = 8'h00;
  logic [6:0] RD_ADDR = 7'h00;
  logic [7:0] LCD_DATA_OUT, WR_CHAR, RD_CHAR;
  logic [6:0] AC, WR_ADDR;
  logic LCD_DATA_OE, BUSY, DISP_ON, CURSOR_ON, BLINK_ON, ENTRY_ID, ENTRY_S;
  logic DL_8BIT, N_2LINE, WR_STB, CMD_ERR;

  lcd_char_responder #(.BUSY_CYC(4), .CLR_CYC(128)) dut (
    .CLK(CLK), .RESETN(RESETN), .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
    .LCD_DATA_IN(LCD_DATA_IN), .LCD_DATA_OUT(LCD_DATA_OUT), .LCD_DATA_OE(LCD_DATA_OE),
    .BUSY(BUSY), .AC(AC), .DISP_ON(DISP_ON), .CURSOR_ON(CURSOR_ON), .BLINK_ON(BLINK_ON),
    .ENTRY_ID(ENTRY_ID), .ENTRY_S(ENTRY_S), .DL_8BIT(DL_8BIT), .N_2LINE(N_2LINE),
    .WR_STB(WR_STB), .WR_ADDR(WR_ADDR), .WR_CHAR(WR_CHAR), .RD_ADDR(RD_ADDR),
    .RD_CHAR(RD_CHAR), .CMD_ERR(CMD_ERR)
  );

  always #5 CLK = ~CLK;

  wire [6:0] flags = {DL_8BIT, N_2LINE, DISP_ON, CURSOR_ON, BLINK_ON, ENTRY_ID, ENTRY_S};

  int n_tests = 0, n_fail = 0, err_cnt = 0;
  logic [14:0] wr_q [$];

  // Log every committed write and every dropped transfer
  always @(negedge CLK) begin
    if (WR_STB) wr_q.push_back({WR_ADDR, WR_CHAR});
    if (CMD_ERR) err_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One bus transfer: E high for 3 cycles (read data sampled then), low for 3
  task automatic xfer(input logic rs, input logic rw, input logic [7:0] d,
                      output logic [7:0] rd, output logic oe);
    LCD_RS = rs; LCD_RW = rw; LCD_DATA_IN = d; LCD_E = 1'b1;
    repeat (3) @(negedge CLK);
    rd = LCD_DATA_OUT; oe = LCD_DATA_OE;
    LCD_E = 1'b0;
    repeat (3) @(negedge CLK);
    LCD_RW = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (BUSY && n < 400) begin @(negedge CLK); n++; end
    if (BUSY) begin
      n_tests++; n_fail++;
      $display("FAIL busy_timeout: got BUSY=1 after %0d cycles, expected 0", n);
    end
  endtask

  task automatic wr(input logic rs, input logic [7:0] d);
    logic [7:0] rd; logic oe;
    xfer(rs, 1'b0, d, rd, oe);
    wait_idle();
  endtask

  task automatic peek(input string name, input logic [6:0] a, input logic [7:0] exp);
    RD_ADDR = a; #1;
    check(name, RD_CHAR, exp);
  endtask

  // Reference model: cursor as a linear screen position, DDRAM as an array
  function automatic logic [6:0] m_step(input logic [6:0] a, input logic inc, input logic n2);
    int p;
    p = (n2 && a >= 7'h40) ? 40 + (int'(a) - 64) : int'(a);
    p = inc ? (p + 1) % 80 : (p + 79) % 80;
    if (n2 && p >= 40) return 7'(64 + p - 40);
    return 7'(p);
  endfunction

  typedef struct { logic rs; logic [7:0] d; logic [6:0] ac; logic [6:0] fl; } vec_t;
  vec_t tbl [11];

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd, c, cmd;
    logic oe;
    logic [6:0] pac, mac, a;
    logic [7:0] mddram [128];
    logic m_dl, m_n, m_d, m_c, m_b, m_id, m_s;
    int n, e0, op, x;

    // {rs, data, expected AC, expected {DL,N,D,C,B,ID,S}}
    tbl[0]  = '{1'b0, 8'h3C, 7'h00, 7'b1100010};
    tbl[1]  = '{1'b0, 8'h0C, 7'h00, 7'b1110010};
    tbl[2]  = '{1'b0, 8'h06, 7'h00, 7'b1110010};
    tbl[3]  = '{1'b0, 8'h80, 7'h00, 7'b1110010};
    tbl[4]  = '{1'b1, 8'h2A, 7'h01, 7'b1110010};
    tbl[5]  = '{1'b1, 8'h2E, 7'h02, 7'b1110010};
    tbl[6]  = '{1'b0, 8'hA7, 7'h27, 7'b1110010};
    tbl[7]  = '{1'b1, 8'h41, 7'h40, 7'b1110010};
    tbl[8]  = '{1'b0, 8'h04, 7'h40, 7'b1110000};
    tbl[9]  = '{1'b0, 8'hC0, 7'h40, 7'b1110000};
    tbl[10] = '{1'b1, 8'h42, 7'h27, 7'b1110000};

    repeat (2) @(negedge CLK);
    check("rst_busy", BUSY, 1);
    check("rst_ac", AC, 0);
    check("rst_flags", flags, 7'b1000010);
    check("rst_wr_stb", WR_STB, 0);
    check("rst_cmd_err", CMD_ERR, 0);
    check("rst_oe", LCD_DATA_OE, 0);

    RESETN = 1'b0;
    n = 0;
    while (BUSY && n < 300) begin n++; @(negedge CLK); end
    check("rst_busy_cycles", n, 128);
    peek("rst_char_00", 7'h00, 8'h20);
    peek("rst_char_40", 7'h40, 8'h20);
    peek("rst_char_7f", 7'h7F, 8'h20);

    // Directed table: setup, writes, line wrap and decrement
    pac = 7'h00;
    for (int i = 0; i < 11; i++) begin
      wr_q.delete();
      wr(tbl[i].rs, tbl[i].d);
      check($sformatf("tbl%0d_ac", i), AC, tbl[i].ac);
      check($sformatf("tbl%0d_flags", i), flags, tbl[i].fl);
      if (tbl[i].rs) begin
        check($sformatf("tbl%0d_wr_cnt", i), wr_q.size(), 1);
        if (wr_q.size() > 0) check($sformatf("tbl%0d_wr_log", i), wr_q[0], {pac, tbl[i].d});
        peek($sformatf("tbl%0d_ddram", i), pac, tbl[i].d);
      end
      pac = tbl[i].ac;
    end

    // Write during clear is dropped; status reads reflect busy
    @(negedge CLK);
    e0 = err_cnt; wr_q.delete();
    xfer(1'b0, 1'b0, 8'h01, rd, oe);
    xfer(1'b1, 1'b0, 8'h55, rd, oe);
    check("clr_cmd_err", err_cnt - e0, 1);
    xfer(1'b0, 1'b1, 8'h00, rd, oe);
    check("clr_status_busy", rd, 8'h80);
    check("clr_status_oe", oe, 1);
    wait_idle();
    xfer(1'b0, 1'b1, 8'h00, rd, oe);
    check("clr_status_idle", rd, 8'h00);
    check("clr_no_wr", wr_q.size(), 0);
    check("clr_flags", flags, 7'b1110010);
    peek("clr_char_00", 7'h00, 8'h20);
    peek("clr_char_40", 7'h40, 8'h20);

    // Reset during a data write's busy window
    @(negedge CLK);
    wr(1'b0, 8'h85);
    xfer(1'b1, 1'b0, 8'h77, rd, oe);
    check("pre_rst_busy", BUSY, 1);
    peek("pre_rst_char", 7'h05, 8'h77);
    RESETN = 1'b1;
    repeat (2) @(negedge CLK);
    check("mid_rst_busy", BUSY, 1);
    check("mid_rst_ac", AC, 0);
    check("mid_rst_flags", flags, 7'b1000010);
    check("mid_rst_wr_stb", WR_STB, 0);
    RESETN = 1'b0;
    @(negedge CLK);
    wait_idle();
    peek("post_rst_char", 7'h05, 8'h20);

    // One-line mode wraps modulo 80 in both directions
    @(negedge CLK);
    wr(1'b0, 8'hCF);
    wr(1'b1, 8'h31);
    check("n1_inc_wrap_ac", AC, 7'h00);
    wr(1'b0, 8'h04);
    wr(1'b1, 8'h32);
    check("n1_dec_wrap_ac", AC, 7'h4F);
    peek("n1_char_4f", 7'h4F, 8'h31);
    peek("n1_char_00", 7'h00, 8'h32);

    // Random traffic against the model (two-line mode)
    for (int i = 0; i < 128; i++) mddram[i] = 8'h20;
    mddram[7'h4F] = 8'h31; mddram[0] = 8'h32;
    m_dl = 1; m_n = 1; m_d = 0; m_c = 0; m_b = 0; m_id = 0; m_s = 0;
    @(negedge CLK);
    wr(1'b0, 8'h38);
    wr(1'b0, 8'h80);
    mac = 7'h00;
    for (int it = 0; it < 80; it++) begin
      op = $urandom_range(0, 12);
      case (op)
        0, 1, 2, 3: begin
          c = 8'($urandom_range(8'h21, 8'h7E));
          wr_q.delete();
          wr(1'b1, c);
          check("rnd_wr_cnt", wr_q.size(), 1);
          if (wr_q.size() > 0) check("rnd_wr_log", wr_q[0], {mac, c});
          mddram[mac] = c;
          mac = m_step(mac, m_id, m_n);
        end
        4: begin
          xfer(1'b1, 1'b1, 8'h00, rd, oe);
          check("rnd_data_read", rd, mddram[mac]);
          mac = m_step(mac, m_id, m_n);
          wait_idle();
        end
        5: begin
          xfer(1'b0, 1'b1, 8'h00, rd, oe);
          check("rnd_status_read", rd, {1'b0, mac});
        end
        6: begin
          x = $urandom_range(0, 39);
          a = 7'(x) + (($urandom_range(0, 1) == 1) ? 7'h40 : 7'h00);
          wr(1'b0, {1'b1, a});
          mac = a;
        end
        7: begin
          x = $urandom_range(0, 3);
          wr(1'b0, 8'h04 | 8'(x));
          m_id = x[1]; m_s = x[0];
        end
        8: begin
          x = $urandom_range(0, 7);
          wr(1'b0, 8'h08 | 8'(x));
          m_d = x[2]; m_c = x[1]; m_b = x[0];
        end
        9: begin
          x = $urandom_range(0, 3);
          cmd = 8'h10 | 8'(x << 2);
          wr(1'b0, cmd);
          if (!x[1]) mac = m_step(mac, x[0], m_n);
        end
        10: begin
          wr(1'b0, 8'h02);
          mac = 7'h00;
        end
        11: begin
          wr(1'b0, 8'h01);
          mac = 7'h00; m_id = 1;
          for (int k = 0; k < 128; k++) mddram[k] = 8'h20;
        end
        default: begin
          x = $urandom_range(0, 1);
          wr(1'b0, 8'h28 | 8'(x << 4));
          m_dl = x[0];
        end
      endcase
      check("rnd_ac", AC, mac);
      check("rnd_flags", flags, {m_dl, m_n, m_d, m_c, m_b, m_id, m_s});
      a = 7'($urandom_range(0, 127));
      peek("rnd_ddram", a, mddram[a]);
      @(negedge CLK);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
